// File: rtl/secuenciador_fir_mac.sv
// NTAPS-tap FIR sequencer driving one shared external multiply-add-truncate datapath, one tap per clock.
// Optional macro FIR_DESBORDE_STICKY_EN: desborde reports an overflow from any tap instead of the last one only.
module secuenciador_fir_mac #(
  parameter int unsigned ANCHO = 16,
  parameter int unsigned NTAPS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ANCHO-1:0] muestra,
  input  logic             muestra_valida,
  output logic             listo,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [ANCHO-1:0] coef_data,
  output logic [ANCHO-1:0] mac_op1,
  output logic [ANCHO-1:0] mac_op2,
  output logic [ANCHO-1:0] mac_op3,
  input  logic [ANCHO-1:0] mac_resultado,
  input  logic             mac_desborde,
  output logic [ANCHO-1:0] salida,
  output logic             salida_valida,
  output logic             desborde
);

  typedef enum logic {REPOSO, MAC} estado_t;

  localparam logic [AW-1:0] K_ULTIMO = AW'(NTAPS - 1);

  estado_t          estado_q, estado_d;
  logic [AW-1:0]    k_q, k_d;
  logic [AW-1:0]    k_sig;
  logic [ANCHO-1:0] x_q [NTAPS];
  logic [ANCHO-1:0] x_d [NTAPS];
  logic [ANCHO-1:0] c_q [NTAPS];
  logic [ANCHO-1:0] c_d [NTAPS];
  logic [ANCHO-1:0] op1_q, op1_d;
  logic [ANCHO-1:0] op2_q, op2_d;
  logic [ANCHO-1:0] op3_q, op3_d;
  logic [ANCHO-1:0] salida_q, salida_d;
  logic             valida_q, valida_d;
  logic             desb_q, desb_d;
  logic             listo_q, listo_d;
`ifdef FIR_DESBORDE_STICKY_EN
  logic             ov_acum_q, ov_acum_d;
`endif

  assign k_sig = k_q + AW'(1);

  // Operands are registered: they are prepared for the tap that the next cycle will compute.
  always_comb begin
    estado_d = estado_q;
    k_d      = k_q;
    x_d      = x_q;
    c_d      = c_q;
    op1_d    = '0;
    op2_d    = '0;
    op3_d    = '0;
    salida_d = salida_q;
    valida_d = 1'b0;
    desb_d   = desb_q;
`ifdef FIR_DESBORDE_STICKY_EN
    ov_acum_d = ov_acum_q;
`endif

    unique case (estado_q)
      REPOSO: begin
        // Bank write lands before the accept so tap 0 already sees the new coefficient.
        if (coef_we && (32'(coef_addr) < NTAPS)) begin
          c_d[coef_addr] = coef_data;
        end
        if (muestra_valida) begin
          for (int i = NTAPS - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]   = muestra;
          k_d      = '0;
          op1_d    = c_d[0];
          op2_d    = muestra;
          op3_d    = '0;
          estado_d = MAC;
`ifdef FIR_DESBORDE_STICKY_EN
          ov_acum_d = 1'b0;
          desb_d    = 1'b0;
`endif
        end
      end
      MAC: begin
`ifdef FIR_DESBORDE_STICKY_EN
        ov_acum_d = ov_acum_q | mac_desborde;
`endif
        if (k_q == K_ULTIMO) begin
          salida_d = mac_resultado;
          valida_d = 1'b1;
`ifdef FIR_DESBORDE_STICKY_EN
          desb_d   = ov_acum_q | mac_desborde;
`else
          desb_d   = mac_desborde;
`endif
          estado_d = REPOSO;
        end else begin
          k_d   = k_sig;
          op1_d = c_q[k_sig];
          op2_d = x_q[k_sig];
          op3_d = mac_resultado;
        end
      end
      default: estado_d = REPOSO;
    endcase

    listo_d = (estado_d == REPOSO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= REPOSO;
      k_q      <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
      salida_q <= '0;
      valida_q <= 1'b0;
      desb_q   <= 1'b0;
      listo_q  <= 1'b1;
`ifdef FIR_DESBORDE_STICKY_EN
      ov_acum_q <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      k_q      <= k_d;
      x_q      <= x_d;
      c_q      <= c_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      salida_q <= salida_d;
      valida_q <= valida_d;
      desb_q   <= desb_d;
      listo_q  <= listo_d;
`ifdef FIR_DESBORDE_STICKY_EN
      ov_acum_q <= ov_acum_d;
`endif
    end
  end

  assign listo         = listo_q;
  assign mac_op1       = op1_q;
  assign mac_op2       = op2_q;
  assign mac_op3       = op3_q;
  assign salida        = salida_q;
  assign salida_valida = valida_q;
  assign desborde      = desb_q;

endmodule

// File: tb/tb_secuenciador_fir_mac.sv
// Bench for secuenciador_fir_mac: supplies a Q8.8 signed datapath and compares each filter result
// against a tap-by-tap reference of the FIR equation. Honours FIR_DESBORDE_STICKY_EN like the DUT.
module tb_secuenciador_fir_mac;

  localparam int unsigned ANCHO = 16;
  localparam int unsigned NTAPS = 4;
  localparam int unsigned AW    = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [ANCHO-1:0] muestra;
  logic             muestra_valida;
  logic             listo;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [ANCHO-1:0] coef_data;
  logic [ANCHO-1:0] mac_op1, mac_op2, mac_op3;
  logic [ANCHO-1:0] mac_resultado;
  logic             mac_desborde;
  logic [ANCHO-1:0] salida;
  logic             salida_valida;
  logic             desborde;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference state: coefficient bank and sample history, newest sample at index 0.
  logic signed [15:0] coef_m [NTAPS];
  logic signed [15:0] hist_m [NTAPS];
  logic               desb_m;

  secuenciador_fir_mac #(.ANCHO(ANCHO), .NTAPS(NTAPS), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .muestra(muestra), .muestra_valida(muestra_valida),
    .listo(listo), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_op1(mac_op1), .mac_op2(mac_op2), .mac_op3(mac_op3),
    .mac_resultado(mac_resultado), .mac_desborde(mac_desborde),
    .salida(salida), .salida_valida(salida_valida), .desborde(desborde)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared datapath: (op1*op2)>>>8 + op3, wrapped to 16 bits, flag when the true sum does not fit.
  int dp_full;
  always_comb dp_full = ((int'($signed(mac_op1)) * int'($signed(mac_op2))) >>> 8) + int'($signed(mac_op3));
  assign mac_resultado = dp_full[15:0];
  assign mac_desborde  = (dp_full > 32767) || (dp_full < -32768);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], each partial sum truncated to 16 bits as the datapath does.
  function automatic void ref_fir(output logic [15:0] y, output logic ov);
    int acc;
    int full;
    logic signed [15:0] t;
    logic any_ov, last_ov;
    acc = 0; any_ov = 1'b0; last_ov = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      full    = ((int'(coef_m[k]) * int'(hist_m[k])) >>> 8) + acc;
      last_ov = (full > 32767) || (full < -32768);
      any_ov  = any_ov | last_ov;
      t       = 16'(full);
      acc     = int'(t);
    end
    y = 16'(acc);
`ifdef FIR_DESBORDE_STICKY_EN
    ov = any_ov;
`else
    ov = last_ov;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      coef_m[i] = '0;
      hist_m[i] = '0;
    end
    desb_m = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] s);
    for (int i = NTAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = s;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    muestra_valida = 1'b0; coef_we = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic wcoef(input int k, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = AW'(k); coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[k] = d;
  endtask

  // Offer one sample (optionally with a same-cycle coef write, optionally poking inputs mid-MAC).
  task automatic send(input logic [15:0] s, input bit wr, input int wa, input logic [15:0] wd, input bit poke);
    int n;
    logic [15:0] y_exp;
    logic ov_exp;
    n = 0;
    while (!listo && n < 20) begin @(negedge clk); n++; end
    check("listo_before_accept", 32'(listo), 32'(1));
    muestra = s; muestra_valida = 1'b1;
    coef_we = wr; coef_addr = AW'(wa); coef_data = wd;
    @(negedge clk);
    muestra_valida = 1'b0; coef_we = 1'b0;
    if (wr) coef_m[wa] = wd;
    model_push(s);
    ref_fir(y_exp, ov_exp);
    check("listo_busy", 32'(listo), 32'(0));
`ifdef FIR_DESBORDE_STICKY_EN
    check("desborde_clear_on_accept", 32'(desborde), 32'(0));
`else
    check("desborde_held_on_accept", 32'(desborde), 32'(desb_m));
`endif
    n = 1;
    while (!salida_valida && n < 20) begin
      if (poke && n == 2) begin
        muestra_valida = 1'b1; muestra = 16'($urandom);
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'($urandom);
      end else begin
        muestra_valida = 1'b0; coef_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    muestra_valida = 1'b0; coef_we = 1'b0;
    check("latency", 32'(n), 32'(5));
    check("salida", 32'(salida), 32'(y_exp));
    check("desborde", 32'(desborde), 32'(ov_exp));
    desb_m = ov_exp;
    @(negedge clk);
    check("valida_pulse", 32'(salida_valida), 32'(0));
  endtask

  initial begin
    logic [15:0] y_exp;
    logic ov_exp;
    int last_cyc;
    int n;
    muestra = '0; coef_addr = '0; coef_data = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_listo", 32'(listo), 32'(1));
    check("rst_salida", 32'(salida), 32'(0));
    check("rst_valida", 32'(salida_valida), 32'(0));
    check("rst_desborde", 32'(desborde), 32'(0));
    check("rst_op1", 32'(mac_op1), 32'(0));

    // Impulse response, with busy-time pokes on two samples
    wcoef(0, 16'h0100); wcoef(1, 16'h0080); wcoef(2, 16'h0040); wcoef(3, 16'h0020);
    send(16'h0100, 1'b0, 0, '0, 1'b0);
    check("imp0", 32'(salida), 32'h0100);
    send(16'h0000, 1'b0, 0, '0, 1'b1);
    check("imp1", 32'(salida), 32'h0080);
    send(16'h0000, 1'b0, 0, '0, 1'b1);
    check("imp2", 32'(salida), 32'h0040);
    send(16'h0000, 1'b0, 0, '0, 1'b0);
    check("imp3", 32'(salida), 32'h0020);

    // Reset in the middle of a computation
    muestra = 16'h1234; muestra_valida = 1'b1;
    @(negedge clk);
    muestra_valida = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("amid_salida", 32'(salida), 32'(0));
    check("amid_valida", 32'(salida_valida), 32'(0));
    check("amid_listo", 32'(listo), 32'(1));
    check("amid_desborde", 32'(desborde), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    n = 0;
    repeat (8) begin @(negedge clk); if (salida_valida) n++; end
    check("amid_no_valida", 32'(n), 32'(0));

    // Back-to-back with muestra_valida held high
    for (int k = 0; k < NTAPS; k++) wcoef(k, 16'h0100);
    muestra = 16'h0100; muestra_valida = 1'b1;
    last_cyc = 0;
    for (int r = 0; r < 5; r++) begin
      model_push(16'h0100);
      ref_fir(y_exp, ov_exp);
      n = 0;
      while (!salida_valida && n < 20) begin @(negedge clk); n++; end
      if (r == 4) muestra_valida = 1'b0;
      check("b2b_salida", 32'(salida), 32'(y_exp));
      if (r > 0) check("b2b_interval", 32'(cyc - last_cyc), 32'(5));
      last_cyc = cyc;
      @(negedge clk);
    end
    check("b2b_last", 32'(salida), 32'h0400);
    desb_m = desborde;

    // Same-cycle coefficient write and accept
    do_reset();
    send(16'h0100, 1'b1, 0, 16'h0200, 1'b0);
    check("wr_accept", 32'(salida), 32'h0200);

    // Overflow
    for (int k = 0; k < NTAPS; k++) wcoef(k, 16'h7FFF);
    for (int r = 0; r < 5; r++) send(16'h7FFF, 1'b0, 0, '0, 1'b0);
    send(16'h0000, 1'b0, 0, '0, 1'b0);

    // Randomized coefficients and samples
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) wcoef(int'($urandom_range(0, NTAPS - 1)), 16'($urandom));
      send(16'($urandom), bit'($urandom_range(0, 1)), int'($urandom_range(0, NTAPS - 1)),
           16'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
